// File: rtl/fetch_seq_pkg.sv
// Shared encodings for the fetch/execute sequencer: FSM states, jump types
// and the default reset PC.
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EXEC  = 2'b01,
        S_HALT  = 2'b10
    } state_t;

    localparam logic [1:0] JMP_SEQ = 2'b00;
    localparam logic [1:0] JMP_BEQ = 2'b01;
    localparam logic [1:0] JMP_J   = 2'b10;
    localparam logic [1:0] JMP_JR  = 2'b11;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/fetch_seq_next_pc_sel.sv
// Combinational next-PC selection from the jump type and offset that the
// datapath returns when it finishes an instruction.
module next_pc_sel
    import fetch_seq_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  jmp_type,
    input  logic [31:0] imm_addr_offset,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc
);

    logic [31:0] pc_plus4;
    logic [31:0] branch_disp;

    assign pc_plus4    = pc + 32'd4;
    // Word offset shifted to bytes, then sign-extended from bit 17.
    assign branch_disp = {{14{imm_addr_offset[15]}}, imm_addr_offset[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        case (jmp_type)
            JMP_SEQ: next_pc = pc_plus4;
            JMP_BEQ: next_pc = pc_plus4 + branch_disp;
            JMP_J:   next_pc = {pc[31:28], imm_addr_offset[25:0], 2'b00};
            JMP_JR:  next_pc = jr_target;
            default: next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_seq.sv
// Multi-cycle fetch/execute sequencer: sole owner of the PC, fetches over a
// req/ack handshake, holds ir during execution, then commits the next PC.
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    input  logic        ex_done,
    input  logic [1:0]  jmp_type,
    input  logic [31:0] imm_addr_offset,
    input  logic [31:0] jr_target,
    input  logic        halt,
    output logic [31:0] pc,
    output logic        fault,
    output logic [31:0] retired
);

    state_t      state;
    state_t      state_next;
    logic [31:0] next_pc;
    logic        misaligned;
    logic        fetch_fire;
    logic        exec_fire;

    next_pc_sel u_next_pc_sel (
        .pc              (pc),
        .jmp_type        (jmp_type),
        .imm_addr_offset (imm_addr_offset),
        .jr_target       (jr_target),
        .next_pc         (next_pc)
    );

    assign imem_addr = pc;

    // A misaligned PC is caught before any request goes out, so imem_req is
    // also gated by the alignment check and by reset.
    always_comb begin
        state_next = state;
        misaligned = 1'b0;
        fetch_fire = 1'b0;
        exec_fire  = 1'b0;
        case (state)
            S_FETCH: begin
                if (pc[1:0] != 2'b00) begin
                    misaligned = 1'b1;
                    state_next = S_HALT;
                end else if (imem_ack) begin
                    fetch_fire = 1'b1;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (ex_done) begin
                    exec_fire  = 1'b1;
                    state_next = halt ? S_HALT : S_FETCH;
                end
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_HALT;
        endcase
        imem_req = (state == S_FETCH) && !fault && !misaligned && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            ir       <= 32'h0;
            ir_valid <= 1'b0;
            fault    <= 1'b0;
            retired  <= 32'h0;
        end else begin
            state <= state_next;
            if (misaligned) begin
                fault <= 1'b1;
            end
            if (fetch_fire) begin
                ir       <= imem_rdata;
                ir_valid <= 1'b1;
            end
            if (exec_fire) begin
                pc      <= next_pc;
                retired <= retired + 32'd1;
            end
            if (exec_fire || state_next == S_HALT) begin
                ir_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed self-checking bench for fetch_seq with hand-computed expectations.
module tb_fetch_seq;
    import fetch_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic        ex_done;
    logic [1:0]  jmp_type;
    logic [31:0] imm_addr_offset;
    logic [31:0] jr_target;
    logic        halt;
    logic [31:0] pc;
    logic        fault;
    logic [31:0] retired;

    int tests_run = 0;
    int tests_failed = 0;

    fetch_seq #(.RESET_PC(32'h0000_3000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .ir              (ir),
        .ir_valid        (ir_valid),
        .ex_done         (ex_done),
        .jmp_type        (jmp_type),
        .imm_addr_offset (imm_addr_offset),
        .jr_target       (jr_target),
        .halt            (halt),
        .pc              (pc),
        .fault           (fault),
        .retired         (retired)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge and settle before checks.
    task automatic applyStimulus(input logic ack, input logic [31:0] rdata, input logic exd,
                                 input logic [1:0] jt, input logic [31:0] off,
                                 input logic [31:0] jrt, input logic hlt);
        imem_ack        = ack;
        imem_rdata      = rdata;
        ex_done         = exd;
        jmp_type        = jt;
        imm_addr_offset = off;
        jr_target       = jrt;
        halt            = hlt;
        #1;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, JMP_SEQ, 32'h0, 32'h0, 1'b0);
        cycle();
        rst = 1'b0;
        #1;
    endtask

    // Fetch with immediate ack, then execute with ex_done in the first EXEC cycle.
    task automatic run_instr(input logic [31:0] word, input logic [1:0] jt,
                             input logic [31:0] off, input logic [31:0] jrt, input logic hlt);
        applyStimulus(1'b1, word, 1'b0, JMP_SEQ, 32'h0, 32'h0, 1'b0);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b1, jt, off, jrt, hlt);
        checkOutput("ir_latched", ir, word);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b0, JMP_SEQ, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, JMP_SEQ, 32'h0, 32'h0, 1'b0);
        checkOutput("req_in_reset", 32'(imem_req), 32'd0);
        cycle();
        rst = 1'b0;
        #1;
        checkOutput("rst_pc", pc, 32'h0000_3000);
        checkOutput("rst_ir", ir, 32'h0);
        checkOutput("rst_ir_valid", 32'(ir_valid), 32'd0);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        checkOutput("rst_retired", retired, 32'd0);

        // Slow memory: three wait cycles, then ack.
        for (int i = 0; i < 3; i++) begin
            checkOutput("wait_req", 32'(imem_req), 32'd1);
            checkOutput("wait_addr", imem_addr, 32'h0000_3000);
            cycle();
        end
        applyStimulus(1'b1, 32'h2408_0005, 1'b0, JMP_SEQ, 32'h0, 32'h0, 1'b0);
        checkOutput("ack_req", 32'(imem_req), 32'd1);
        checkOutput("ack_addr", imem_addr, 32'h0000_3000);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b0, JMP_SEQ, 32'h0, 32'h0, 1'b0);
        checkOutput("slow_ir", ir, 32'h2408_0005);
        checkOutput("slow_ir_valid", 32'(ir_valid), 32'd1);
        checkOutput("exec_req", 32'(imem_req), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, JMP_SEQ, 32'h0, 32'h0, 1'b0);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b0, JMP_SEQ, 32'h0, 32'h0, 1'b0);
        checkOutput("seq_pc", pc, 32'h0000_3004);
        checkOutput("seq_retired", retired, 32'd1);
        checkOutput("seq_ir_valid", 32'(ir_valid), 32'd0);

        // beq forward then backward.
        do_reset();
        run_instr(32'h1000_0003, JMP_BEQ, 32'h0000_0003, 32'h0, 1'b0);
        checkOutput("beq_fwd_pc", pc, 32'h0000_3010);
        run_instr(32'h1000_FFFF, JMP_BEQ, 32'h0000_FFFF, 32'h0, 1'b0);
        checkOutput("beq_back_pc", pc, 32'h0000_3010);
        checkOutput("beq_retired", retired, 32'd2);

        // j, then j with upper nibble preserved.
        do_reset();
        run_instr(32'h0800_0C05, JMP_J, 32'h0000_0C05, 32'h0, 1'b0);
        checkOutput("j_pc", pc, 32'h0000_3014);
        run_instr(32'h0000_0008, JMP_JR, 32'h0, 32'h9000_0000, 1'b0);
        checkOutput("jr_pc", pc, 32'h9000_0000);
        run_instr(32'h0800_0C05, JMP_J, 32'h0000_0C05, 32'h0, 1'b0);
        checkOutput("j_nibble_pc", pc, 32'h9000_3014);

        // jr to misaligned target: fault and halt, acks ignored.
        do_reset();
        run_instr(32'h0000_0008, JMP_JR, 32'h0, 32'h0000_3002, 1'b0);
        checkOutput("jr_mis_pc", pc, 32'h0000_3002);
        checkOutput("jr_mis_noreq", 32'(imem_req), 32'd0);
        cycle();
        checkOutput("fault_set", 32'(fault), 32'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'(i % 2 == 0), 32'hDEAD_BEEF, 1'b0, JMP_SEQ, 32'h0, 32'h0, 1'b0);
            checkOutput("fault_req", 32'(imem_req), 32'd0);
            cycle();
        end
        checkOutput("fault_retired", retired, 32'd1);
        checkOutput("fault_pc", pc, 32'h0000_3002);
        checkOutput("fault_ir_valid", 32'(ir_valid), 32'd0);
        checkOutput("fault_ir", ir, 32'h0000_0008);

        // halt freezes after the pc update.
        do_reset();
        checkOutput("fault_cleared", 32'(fault), 32'd0);
        run_instr(32'h0000_000C, JMP_SEQ, 32'h0, 32'h0, 1'b1);
        checkOutput("halt_pc", pc, 32'h0000_3004);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h1111_1111, 1'b1, JMP_JR, 32'h0, 32'h0000_5000, 1'b0);
            checkOutput("halt_req", 32'(imem_req), 32'd0);
            cycle();
        end
        checkOutput("halt_frozen_pc", pc, 32'h0000_3004);
        checkOutput("halt_frozen_retired", retired, 32'd1);
        checkOutput("halt_frozen_ir", ir, 32'h0000_000C);

        // Reset while waiting for ack in S_FETCH.
        do_reset();
        run_instr(32'h0000_0000, JMP_SEQ, 32'h0, 32'h0, 1'b0);
        cycle();
        checkOutput("pre_rst_req", 32'(imem_req), 32'd1);
        rst = 1'b1;
        applyStimulus(1'b1, 32'hAAAA_5555, 1'b0, JMP_SEQ, 32'h0, 32'h0, 1'b0);
        checkOutput("mid_rst_req", 32'(imem_req), 32'd0);
        cycle();
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, JMP_SEQ, 32'h0, 32'h0, 1'b0);
        checkOutput("mid_rst_pc", pc, 32'h0000_3000);
        checkOutput("mid_rst_retired", retired, 32'd0);
        checkOutput("mid_rst_ir_valid", 32'(ir_valid), 32'd0);
        checkOutput("mid_rst_ir", ir, 32'h0);

        // Spurious ex_done in FETCH and ack in EXEC.
        applyStimulus(1'b0, 32'h0, 1'b1, JMP_JR, 32'h0, 32'hDEAD_0000, 1'b1);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b0, JMP_SEQ, 32'h0, 32'h0, 1'b0);
        checkOutput("spur_exd_pc", pc, 32'h0000_3000);
        checkOutput("spur_exd_retired", retired, 32'd0);
        checkOutput("spur_exd_req", 32'(imem_req), 32'd1);
        applyStimulus(1'b1, 32'h1234_5678, 1'b0, JMP_SEQ, 32'h0, 32'h0, 1'b0);
        cycle();
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, JMP_SEQ, 32'h0, 32'h0, 1'b0);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b0, JMP_SEQ, 32'h0, 32'h0, 1'b0);
        checkOutput("spur_ack_ir", ir, 32'h1234_5678);
        checkOutput("spur_ack_valid", 32'(ir_valid), 32'd1);
        checkOutput("spur_ack_pc", pc, 32'h0000_3000);
        applyStimulus(1'b0, 32'h0, 1'b1, JMP_SEQ, 32'h0, 32'h0, 1'b0);
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b0, JMP_SEQ, 32'h0, 32'h0, 1'b0);
        checkOutput("spur_final_pc", pc, 32'h0000_3004);
        checkOutput("spur_final_retired", retired, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Multi-cycle fetch/execute sequencer that owns the architectural PC register and drives next-PC selection.
- Issues instruction-memory requests with a req/ack handshake and latches the fetched word into the instruction register.
- Holds the instruction while the datapath executes it, then commits the next PC from the jump type and offset returned by the datapath.
- Sits between the instruction memory and the decode/execute datapath; it is the only writer of the PC.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- imem_req  output  1  instruction fetch request
- imem_addr  output  32  fetch address, equals pc
- imem_ack  input  1  memory completes fetch this cycle
- imem_rdata  input  32  fetched word, valid when imem_ack=1
- ir  output  32  latched instruction
- ir_valid  output  1  ir holds an instruction awaiting execution
- ex_done  input  1  datapath finished executing ir this cycle
- jmp_type  input  2  00 seq, 01 beq-taken, 10 j, 11 jr; sampled with ex_done
- imm_addr_offset  input  32  branch/jump immediate; sampled with ex_done
- jr_target  input  32  register target for jr; sampled with ex_done
- halt  input  1  stop after the current instruction; sampled with ex_done
- pc  output  32  current PC
- fault  output  1  sticky misaligned-fetch flag
- retired  output  32  count of completed instructions

Behaviour:
- Reset values: pc=RESET_PC, state=S_FETCH, imem_req=0, ir=0, ir_valid=0, fault=0, retired=0.
- rst dominates every other input in any state, including mid-handshake. imem_req is 0 in the reset cycle itself.
- States are S_FETCH=2'b00, S_EXEC=2'b01, S_HALT=2'b10. Encoding 2'b11 is unreachable and recovers to S_HALT.
- imem_req is combinational: 1 only in S_FETCH with fault=0. imem_addr=pc at all times.
- S_FETCH, entry check: if pc[1:0]!=0, set fault<=1 and go to S_HALT; no request is issued.
- S_FETCH, handshake: hold imem_req=1 with imem_addr stable until imem_ack=1. In that cycle: ir<=imem_rdata, ir_valid<=1, go to S_EXEC. No limit on ack wait.
- S_EXEC: ir and ir_valid stay stable until ex_done=1. In that cycle:
  - pc<=next_pc;
  - retired<=retired+1, wrapping at 2^32;
  - ir_valid<=0;
  - go to S_HALT if halt=1, else S_FETCH.
- next_pc (32-bit, overflow wraps):
  - 00: pc+4
  - 01: pc+4+sext({imm_addr_offset[15:0],2'b00}) — 18-bit value sign-extended to 32
  - 10: {pc[31:28], imm_addr_offset[25:0], 2'b00}
  - 11: jr_target, unmodified
- S_HALT: imem_req=0; pc, ir and retired are frozen; ir_valid=0. Exit only via rst.
- Ignored inputs:
  - imem_ack outside S_FETCH;
  - ex_done outside S_EXEC;
  - jmp_type, offsets and halt whenever ex_done=0.
- Throughput: minimum 2 cycles per instruction (ack in the first S_FETCH cycle, ex_done in the first S_EXEC cycle).

Decomposition:
- Shared package holds:
  - state encodings S_FETCH, S_EXEC, S_HALT;
  - jump-type constants JMP_SEQ=2'b00, JMP_BEQ=2'b01, JMP_J=2'b10, JMP_JR=2'b11;
  - the default reset PC constant.
- One combinational sub-module, next_pc_sel, with inputs pc, jmp_type, imm_addr_offset and jr_target, and output next_pc. The FSM, PC register, ir and counter stay in fetch_seq.

Test Plan:
- Sequential fetch with slow memory: reset, hold imem_ack=0 for 3 cycles, then ack with rdata=0x2408_0005.
  - imem_req=1 and imem_addr=0x3000 held stable for all 4 cycles; ir=0x2408_0005 and ir_valid=1 the next cycle.
  - ex_done with jmp 00 gives pc=0x3004, retired=1.
- beq both directions from pc=0x3000:
  - offset 0x0003 gives pc=0x3010.
  - Then from 0x3010, offset 0xFFFF gives pc=0x3010 (pc+4-4).
- j from pc=0x3000 with offset 0x0000_0C05: pc=0x0000_3014; upper nibble preserved when pc=0x9000_0000 (result 0x9000_3014).
- jr to misaligned target 0x0000_3002: pc=0x3002; next cycle fault=1, state S_HALT, imem_req=0 indefinitely, ack pulses ignored, retired unchanged.
- halt and recovery: halt=1 with ex_done freezes in S_HALT after the pc update. Later, rst asserted while in S_FETCH waiting for ack returns pc=0x3000, retired=0, fault=0, and imem_req=0 that cycle.
- Spurious inputs ignored: ex_done=1 pulsed during S_FETCH, and imem_ack=1 pulsed during S_EXEC, leave pc, ir and retired unchanged.
